misr_signature_checker: RTL and testbench



---
 rtl/misr_signature_checker.sv | 100 ++++++++++
 tb/tb_misr_signature_checker.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/misr_signature_checker.sv
// Multiple-input signature register with run/compare controller.
// Compacts CH response bits per valid cycle over PATTERNS samples,
// then compares the signature against a golden value.
module misr_signature_checker #(
   parameter int               WIDTH    = 16,
   parameter int               CH       = 16,
   parameter logic [WIDTH-1:0] POLY     = 16'h8016,
   parameter logic [WIDTH-1:0] SEED     = '0,
   parameter int               PATTERNS = 255
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [CH-1:0]    din,
   input  logic             din_valid,
   input  logic [WIDTH-1:0] golden,
   output logic [WIDTH-1:0] sig,
   output logic             busy,
   output logic             done,
   output logic             pass
);

   localparam int CW = $clog2(PATTERNS + 1);
   localparam logic [CW-1:0] LAST = CW'(PATTERNS - 1);

   typedef enum logic [1:0] {IDLE, RUN, CMP, DONE} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] sig_q, sig_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             done_q, done_d;
   logic             pass_q, pass_d;
   logic [WIDTH-1:0] d_ext;
   logic [WIDTH-1:0] sig_nxt;

   // Right-shift Galois step with din injected in parallel (zero-extended).
   always_comb begin
      d_ext          = '0;
      d_ext[CH-1:0]  = din;
      sig_nxt        = (sig_q >> 1) ^ ({WIDTH{sig_q[0]}} & POLY) ^ d_ext;
   end

   // Next-state and datapath control; start overrides every state.
   always_comb begin
      state_d = state_q;
      sig_d   = sig_q;
      cnt_d   = cnt_q;
      done_d  = done_q;
      pass_d  = pass_q;
      if (start) begin
         // Reseed and (re)enter RUN; a sample in this cycle is dropped.
         state_d = RUN;
         sig_d   = SEED;
         cnt_d   = '0;
         done_d  = 1'b0;
         pass_d  = 1'b0;
      end else begin
         unique case (state_q)
            IDLE: ;
            RUN: begin
               if (din_valid) begin
                  sig_d = sig_nxt;
                  cnt_d = cnt_q + 1'b1;
                  if (cnt_q == LAST) state_d = CMP;
               end
            end
            CMP: begin
               pass_d  = (sig_q == golden);
               done_d  = 1'b1;
               state_d = DONE;
            end
            DONE: ;
            default: state_d = IDLE;
         endcase
      end
   end

   // State registers; synchronous reset wins over start.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         sig_q   <= SEED;
         cnt_q   <= '0;
         done_q  <= 1'b0;
         pass_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         sig_q   <= sig_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
         pass_q  <= pass_d;
      end
   end

   assign sig  = sig_q;
   assign busy = (state_q == RUN) || (state_q == CMP);
   assign done = done_q;
   assign pass = pass_q;

endmodule

// File: tb/tb_misr_signature_checker.sv
// Directed bench: a 4-bit MISR with hand-computed signatures and a
// default 16-bit MISR checked against a bit-level reference model.
module tb_misr_signature_checker;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // 4-bit instance
   logic       a_reset, a_start, a_valid;
   logic [3:0] a_din, a_golden, a_sig;
   logic       a_busy, a_done, a_pass;

   misr_signature_checker #(
      .WIDTH(4), .CH(4), .POLY(4'h9), .SEED(4'h0), .PATTERNS(3)
   ) u_a (
      .clk(clk), .reset(a_reset), .start(a_start), .din(a_din),
      .din_valid(a_valid), .golden(a_golden), .sig(a_sig),
      .busy(a_busy), .done(a_done), .pass(a_pass)
   );

   // 16-bit default instance, seeded with 1
   logic        b_reset, b_start, b_valid;
   logic [15:0] b_din, b_golden, b_sig;
   logic        b_busy, b_done, b_pass;

   misr_signature_checker #(
      .SEED(16'h0001)
   ) u_b (
      .clk(clk), .reset(b_reset), .start(b_start), .din(b_din),
      .din_valid(b_valid), .golden(b_golden), .sig(b_sig),
      .busy(b_busy), .done(b_done), .pass(b_pass)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   // advance one edge, then settle before sampling/driving
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // feed one valid sample to the 4-bit instance
   task automatic feed_a(input logic [3:0] d);
      a_din   = d;
      a_valid = 1'b1;
      tick();
      a_valid = 1'b0;
   endtask

   task automatic start_a();
      a_start = 1'b1;
      a_valid = 1'b1;
      a_din   = 4'hF;
      tick();
      a_start = 1'b0;
      a_valid = 1'b0;
   endtask

   // reference step: next[i] = q[i+1] ^ (q[0] & POLY[i]) ^ d[i], q[16]=0
   function automatic logic [15:0] ref16(input logic [15:0] q, input logic [15:0] d);
      logic [15:0] p;
      logic [15:0] n;
      p = 16'h8016;
      for (int i = 0; i < 16; i++)
         n[i] = ((i < 15) ? q[i+1] : 1'b0) ^ (q[0] & p[i]) ^ d[i];
      return n;
   endfunction

   initial begin
      logic [15:0] m;
      int          bcnt;

      a_reset = 1'b1; a_start = 1'b0; a_valid = 1'b0; a_din = '0; a_golden = '0;
      b_reset = 1'b1; b_start = 1'b0; b_valid = 1'b0; b_din = '0; b_golden = '0;
      tick(); tick();
      chk("rst_sig",  a_sig,  4'h0);
      chk("rst_busy", a_busy, 1'b0);
      chk("rst_done", a_done, 1'b0);
      chk("rst_pass", a_pass, 1'b0);
      chk("rst_bsig", b_sig,  16'h0001);
      a_reset = 1'b0;
      b_reset = 1'b0;

      // run 1: 1,0,0 -> 1,9,D; golden D -> pass
      a_golden = 4'hD;
      start_a();
      chk("r1_seed", a_sig, 4'h0);
      chk("r1_busy", a_busy, 1'b1);
      feed_a(4'h1); chk("r1_s1", a_sig, 4'h1);
      feed_a(4'h0); chk("r1_s2", a_sig, 4'h9);
      feed_a(4'h0); chk("r1_s3", a_sig, 4'hD);
      chk("r1_cmp_done", a_done, 1'b0);
      chk("r1_cmp_busy", a_busy, 1'b1);
      tick();
      chk("r1_done", a_done, 1'b1);
      chk("r1_pass", a_pass, 1'b1);
      chk("r1_idle_busy", a_busy, 1'b0);
      tick();
      chk("r1_sticky", a_done, 1'b1);

      // run 2: golden C -> fail, frozen under random traffic
      a_golden = 4'hC;
      start_a();
      chk("r2_clr_done", a_done, 1'b0);
      feed_a(4'h1); feed_a(4'h0); feed_a(4'h0);
      tick();
      chk("r2_done", a_done, 1'b1);
      chk("r2_pass", a_pass, 1'b0);
      for (int i = 0; i < 10; i++) begin
         a_din   = 4'($urandom_range(0, 15));
         a_valid = 1'($urandom_range(0, 1));
         tick();
      end
      a_valid = 1'b0;
      chk("r2_frz_sig",  a_sig,  4'hD);
      chk("r2_frz_done", a_done, 1'b1);
      chk("r2_frz_pass", a_pass, 1'b0);

      // run 3: gaps with din=F not absorbed
      a_golden = 4'hD;
      start_a();
      feed_a(4'h1);
      a_din = 4'hF;
      tick(); tick(); tick();
      chk("r3_gap_sig", a_sig, 4'h1);
      chk("r3_gap_busy", a_busy, 1'b1);
      feed_a(4'h0); feed_a(4'h0);
      chk("r3_sig", a_sig, 4'hD);
      tick();
      chk("r3_done", a_done, 1'b1);
      chk("r3_pass", a_pass, 1'b1);

      // run 4: abort after 2 samples, restart with F,0,0 -> F,E,7
      a_golden = 4'h7;
      start_a();
      feed_a(4'h1); feed_a(4'h0);
      chk("r4_mid", a_sig, 4'h9);
      start_a();
      chk("r4_reseed", a_sig, 4'h0);
      chk("r4_nodone", a_done, 1'b0);
      feed_a(4'hF); chk("r4_s1", a_sig, 4'hF);
      feed_a(4'h0); chk("r4_s2", a_sig, 4'hE);
      chk("r4_nodone2", a_done, 1'b0);
      feed_a(4'h0); chk("r4_s3", a_sig, 4'h7);
      tick();
      chk("r4_done", a_done, 1'b1);
      chk("r4_pass", a_pass, 1'b1);

      // run 5: reset in CMP with simultaneous start
      a_golden = 4'hD;
      start_a();
      feed_a(4'h1); feed_a(4'h0); feed_a(4'h0);
      chk("r5_in_cmp", a_busy, 1'b1);
      a_reset = 1'b1;
      a_start = 1'b1;
      tick();
      a_reset = 1'b0;
      a_start = 1'b0;
      chk("r5_sig",  a_sig,  4'h0);
      chk("r5_done", a_done, 1'b0);
      chk("r5_pass", a_pass, 1'b0);
      chk("r5_busy", a_busy, 1'b0);
      tick();
      chk("r5_idle", a_busy, 1'b0);

      // 16-bit: 255 all-zero samples from seed 1
      m = 16'h0001;
      for (int i = 0; i < 255; i++) m = ref16(m, 16'h0000);
      b_golden = m;
      b_start  = 1'b1;
      tick();
      b_start  = 1'b0;
      b_valid  = 1'b1;
      b_din    = 16'h0000;
      bcnt     = 0;
      for (int i = 0; i < 400; i++) begin
         if (b_busy) bcnt++;
         tick();
      end
      b_valid = 1'b0;
      chk("b_busy_cycles", bcnt, 256);
      chk("b_sig",  b_sig,  m);
      chk("b_done", b_done, 1'b1);
      chk("b_pass", b_pass, 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
